dcache_wbuf_mem_if: RTL and testbench

//   Parametrised write buffer and memory-port arbiter between a data cache's line port and main memory.

---
 rtl/dcache_wbuf_mem_if.sv | 251 +++++++++++++++++++++++++
 tb/tb_dcache_wbuf_mem_if.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wbuf_mem_if.sv
// dcache_wbuf_mem_if: write buffer plus memory-port arbiter between a data
// cache line port and main memory.
//   - Buffers up to DEPTH dirty-line writebacks in a FIFO. A repeat write to a
//     buffered line merges into it, unless that line is the head currently
//     being written to memory.
//   - Read misses are served from the buffer on an address match, with the
//     youngest matching entry winning. Otherwise they go to memory, ahead of
//     any further drains.
//   - Buffered lines drain to memory in FIFO order whenever the port is idle.
// Ports:
//   clk, proc_reset_n                  clock, async active-low reset
//   c_read/c_write/c_addr/c_wdata      cache request, held until c_ready
//   c_rdata/c_ready                    refill data, one-cycle completion pulse
//   mem_read/mem_write/mem_addr/
//   mem_wdata                          memory request, held until mem_ready
//   mem_rdata/mem_ready                memory read data, one-cycle completion
//   wb_count/wb_full/wb_empty          buffer occupancy
module dcache_wbuf_mem_if #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  wb_count,
  output logic              wb_full,
  output logic              wb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_READ  = 2'd1,
    M_WRITE = 2'd2
  } mstate_e;

  // Buffer storage
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][LINE_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             head_q, head_d;
  logic [PTR_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         wb_full_q, wb_full_d;
  logic                         wb_empty_q, wb_empty_d;

  // Memory port and cache response
  mstate_e                      state_q, state_d;
  logic                         pend_q, pend_d;
  logic [ADDR_W-1:0]            pend_addr_q, pend_addr_d;
  logic                         c_ready_q, c_ready_d;
  logic [LINE_W-1:0]            c_rdata_q, c_rdata_d;
  logic                         mem_read_q, mem_read_d;
  logic                         mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]            mem_wdata_q, mem_wdata_d;

  // Lookup and request decode
  logic                         rd_hit_c, mg_hit_c;
  logic [PTR_W-1:0]             rd_idx_c, mg_idx_c, scan_idx;
  logic                         sample_c, rd_req_c, wr_req_c, rd_miss_c;
  logic                         wr_merge_c, wr_push_c, pop_c;

  // Address match, scanning oldest to youngest so the youngest match wins.
  // The merge target skips the head while it is being written to memory.
  always_comb begin
    rd_hit_c = 1'b0;
    rd_idx_c = '0;
    mg_hit_c = 1'b0;
    mg_idx_c = '0;
    scan_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == c_addr)) begin
        rd_hit_c = 1'b1;
        rd_idx_c = scan_idx;
        if (!((i == 0) && (state_q == M_WRITE))) begin
          mg_hit_c = 1'b1;
          mg_idx_c = scan_idx;
        end
      end
    end
  end

  // A new request is looked at only when nothing is completing or pending.
  // If both c_read and c_write are high, the read wins.
  always_comb begin
    sample_c   = !c_ready_q && !pend_q;
    rd_req_c   = sample_c && c_read;
    wr_req_c   = sample_c && c_write && !c_read;
    rd_miss_c  = rd_req_c && !rd_hit_c;
    wr_merge_c = wr_req_c && mg_hit_c;
    wr_push_c  = wr_req_c && !mg_hit_c && (count_q != FULL_CNT);
    pop_c      = (state_q == M_WRITE) && mem_ready;
  end

  // Buffer update: merge, push at tail, pop at head.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_merge_c) begin
      data_d[mg_idx_c] = c_wdata;
    end
    if (wr_push_c) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = c_addr;
      data_d[tail_q]  = c_wdata;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    case ({wr_push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wb_full_d  = (count_d == FULL_CNT);
    wb_empty_d = (count_d == '0);
  end

  // Memory FSM next state plus registered outputs and cache response.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    c_ready_d   = wr_merge_c || wr_push_c || (rd_req_c && rd_hit_c);
    c_rdata_d   = c_rdata_q;

    if (rd_req_c && rd_hit_c) begin
      c_rdata_d = data_q[rd_idx_c];
    end
    if (rd_miss_c) begin
      pend_d      = 1'b1;
      pend_addr_d = c_addr;
    end

    case (state_q)
      M_IDLE: begin
        // A miss seen this cycle counts as pending, so mem_read rises next cycle.
        if (pend_q || rd_miss_c) begin
          state_d    = M_READ;
          mem_read_d = 1'b1;
          mem_addr_d = pend_q ? pend_addr_q : c_addr;
        end else if (count_q != '0) begin
          state_d     = M_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          // A merge into the head on this same edge must reach memory.
          mem_wdata_d = (wr_merge_c && (mg_idx_c == head_q)) ? c_wdata : data_q[head_q];
        end
      end
      M_READ: begin
        if (mem_ready) begin
          state_d    = M_IDLE;
          mem_read_d = 1'b0;
          pend_d     = 1'b0;
          c_rdata_d  = mem_rdata;
          c_ready_d  = 1'b1;
        end
      end
      M_WRITE: begin
        if (mem_ready) begin
          state_d     = M_IDLE;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = M_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      valid_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wb_full_q   <= 1'b0;
      wb_empty_q  <= 1'b1;
      state_q     <= M_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wb_full_q   <= wb_full_d;
      wb_empty_q  <= wb_empty_d;
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign c_rdata   = c_rdata_q;
  assign c_ready   = c_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_count  = count_q;
  assign wb_full   = wb_full_q;
  assign wb_empty  = wb_empty_q;

endmodule

// File: tb/tb_dcache_wbuf_mem_if.sv
// Testbench for dcache_wbuf_mem_if. Random cache traffic and random memory
// latency are checked against a transaction-level model. The model holds the
// buffered lines as a queue, the memory contents as an array, and, for every
// line, the newest data the cache has written.
module tb_dcache_wbuf_mem_if;

  localparam int unsigned LW = 128;
  localparam int unsigned AW = 28;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 3;
  localparam logic [AW-1:0] BASE = 28'h0ABC120;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          c_read, c_write;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_wdata, c_rdata;
  logic          c_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] wb_count;
  logic          wb_full, wb_empty;

  dcache_wbuf_mem_if #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_full(wb_full), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [LW-1:0] shadow  [0:7];
  logic [LW-1:0] mem_arr [0:7];

  int n_checks = 0;
  int n_err    = 0;

  bit            req_active, req_rd, req_hit, req_imm;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_data;
  int            req_age, idle_cnt;
  bit            allow_new, timeout;
  int            wr_pct, lat_max, mem_wait;
  bit            prev_ready, prev_mw, prev_mr;
  logic [AW-1:0] prev_maddr;
  logic [LW-1:0] prev_mwdata;
  logic [LW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Index of the youngest buffered entry for address a, or -1.
  function automatic int find_young(input logic [AW-1:0] a, input bit skip_head);
    int r = -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].a == a && !(skip_head && i == 0)) r = i;
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: observe at the falling edge, update the model, check,
  // then drive memory response and cache request for the next rising edge.
  task automatic step();
    int   mi;
    ent_t e;
    @(negedge clk);
    if (req_active) req_age++;

    // Write acceptance, judged on the buffer as it stood when it was sampled
    if (c_ready && req_active && !req_rd) begin
      mi = find_young(req_addr, prev_mw);
      chk("wr_accept_legal", 128'(mi >= 0 || q.size() < int'(DP)), 128'd1);
      if (req_imm) chk("wr_ack_latency", 128'(req_age), 128'd1);
      if (mi >= 0) begin
        e = q[mi];
        e.d = req_data;
        q[mi] = e;
      end else begin
        e.a = req_addr;
        e.d = req_data;
        q.push_back(e);
      end
      shadow[req_addr[2:0]] = req_data;
    end

    // A drain that completed last cycle lands in memory and leaves the buffer
    if (prev_ready && prev_mw) begin
      mem_arr[prev_maddr[2:0]] = prev_mwdata;
      if (q.size() > 0) q.delete(0);
    end

    // Cache-side completion
    if (c_ready) begin
      chk("ack_expected", 128'(req_active), 128'd1);
      if (req_active && req_rd) begin
        chk("rd_data", c_rdata, shadow[req_addr[2:0]]);
        if (req_hit) chk("rd_hit_latency", 128'(req_age), 128'd1);
        else         chk("rd_miss_after_mem_ready", 128'(prev_ready && prev_mr), 128'd1);
        last_rdata = shadow[req_addr[2:0]];
      end
      req_active = 1'b0;
      c_read     = 1'b0;
      c_write    = 1'b0;
      idle_cnt   = $urandom_range(0, 3);
    end else begin
      chk("rdata_hold", c_rdata, last_rdata);
    end

    // Occupancy
    chk("wb_count", 128'(wb_count), 128'(q.size()));
    chk("wb_full",  128'(wb_full),  128'(q.size() == int'(DP)));
    chk("wb_empty", 128'(wb_empty), 128'(q.size() == 0));

    // Memory port
    if (prev_ready) chk("mem_idle_gap", 128'(mem_read || mem_write), 128'd0);
    if (mem_write) begin
      chk("mw_nonempty", 128'(q.size() > 0), 128'd1);
      chk("mw_excl", 128'(mem_read), 128'd0);
      if (q.size() > 0) begin
        chk("mw_addr", 128'(mem_addr), 128'(q[0].a));
        chk("mw_data", mem_wdata, q[0].d);
      end
    end
    if (mem_read) begin
      chk("mr_for_miss", 128'(req_active && req_rd && !req_hit), 128'd1);
      chk("mr_addr", 128'(mem_addr), 128'(req_addr));
    end

    // Memory responder
    prev_mw     = mem_write;
    prev_mr     = mem_read;
    prev_maddr  = mem_addr;
    prev_mwdata = mem_wdata;
    if ((mem_read || mem_write) && !prev_ready) begin
      if (mem_wait == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read ? mem_arr[mem_addr[2:0]] : rnd_line();
      end else begin
        mem_wait--;
        mem_ready = 1'b0;
        mem_rdata = rnd_line();
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = rnd_line();
      mem_wait  = $urandom_range(0, lat_max);
    end
    prev_ready = mem_ready;

    if (req_active && req_age > 300) begin
      chk("req_timeout", 128'd0, 128'd1);
      timeout = 1'b1;
    end

    // New cache request
    if (!req_active && !c_ready && allow_new) begin
      if (idle_cnt > 0) begin
        idle_cnt--;
      end else begin
        req_active = 1'b1;
        req_age    = 0;
        req_rd     = ($urandom_range(0, 99) >= wr_pct);
        req_addr   = BASE + AW'($urandom_range(0, 7));
        req_data   = rnd_line();
        req_hit    = find_young(req_addr, 1'b0) >= 0;
        req_imm    = (find_young(req_addr, mem_write) >= 0) || (q.size() < int'(DP));
        c_read     = req_rd;
        c_write    = req_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
        c_addr     = req_addr;
        c_wdata    = req_data;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) shadow[i] = mem_arr[i];
    req_active = 1'b0;
    idle_cnt   = 0;
    prev_ready = 1'b0;
    prev_mw    = 1'b0;
    prev_mr    = 1'b0;
    mem_wait   = 0;
    last_rdata = '0;
    c_read     = 1'b0;
    c_write    = 1'b0;
    mem_ready  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (timeout) break;
    end
  endtask

  initial begin
    bit found;
    bit done;
    for (int i = 0; i < 8; i++) mem_arr[i] = {4{32'hC0DE0000 + 32'(i)}};
    c_addr = '0;
    c_wdata = '0;
    mem_rdata = '0;
    timeout = 1'b0;
    allow_new = 1'b0;
    model_reset();
    proc_reset_n = 1'b1;
    #2 proc_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_c_ready",   128'(c_ready),   128'd0);
    chk("rst_c_rdata",   c_rdata,         128'd0);
    chk("rst_mem_read",  128'(mem_read),  128'd0);
    chk("rst_mem_write", 128'(mem_write), 128'd0);
    chk("rst_wb_count",  128'(wb_count),  128'd0);
    chk("rst_wb_empty",  128'(wb_empty),  128'd1);
    chk("rst_wb_full",   128'(wb_full),   128'd0);
    proc_reset_n = 1'b1;

    // Mixed traffic, short memory latency
    allow_new = 1'b1;
    wr_pct = 50;
    lat_max = 4;
    run(1500);

    // Write-heavy traffic with slow memory to fill the buffer
    wr_pct = 90;
    lat_max = 15;
    if (!timeout) run(400);

    // Reset in the middle of a drain with at least two lines buffered
    found = 1'b0;
    wr_pct = 100;
    lat_max = 10;
    for (int i = 0; i < 3000 && !timeout; i++) begin
      step();
      if (mem_write && wb_count >= CW'(2)) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_hunt_found", 128'(found), 128'd1);
    #2 proc_reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("midrst_mem_write", 128'(mem_write), 128'd0);
    chk("midrst_mem_read",  128'(mem_read),  128'd0);
    chk("midrst_wb_count",  128'(wb_count),  128'd0);
    chk("midrst_wb_empty",  128'(wb_empty),  128'd1);
    chk("midrst_c_ready",   128'(c_ready),   128'd0);
    model_reset();
    @(negedge clk);
    proc_reset_n = 1'b1;

    // More mixed traffic after reset
    wr_pct = 50;
    lat_max = 6;
    if (!timeout) run(1500);

    // Stop issuing, drain everything, then memory must match the cache's view
    allow_new = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !timeout; i++) begin
      step();
      if (!req_active && q.size() == 0 && !mem_write && !mem_read && !prev_ready) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 128'(done), 128'd1);
    for (int i = 0; i < 8; i++) chk("final_mem", mem_arr[i], shadow[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
